// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Two-requester byte scheduler in front of a memory-mapped UART register
//   block. After reset it writes the baud prescaler once, then serves byte
//   requests round-robin: poll the control register until tx_empty
//   (bit 1) is set, write the latched byte to the buffer register and
//   acknowledge the requester.
//
//   Optional feature: define UART_TX_SCHED_TIMEOUT_EN to bound the number
//   of control-register polls per byte to TIMEOUT_POLLS; on expiry the byte
//   is dropped and err pulses for its requester instead of ack.
//
// Parameters
//   UART_ADDRESS  base address (baud = base, control = base+1, buffer = base+2)
//   BAUD_INIT     prescaler written to the baud register after reset
//   TIMEOUT_POLLS poll limit per byte (timeout build only)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   req[1:0]  per-requester byte request, held until ack
//   data0/1   requester bytes, stable while the matching req is high
//   ack[1:0]  one-cycle pulse: byte of that requester written
//   err[1:0]  one-cycle pulse: byte of that requester dropped on timeout
//   bus_addr  UART register address (holds when strobes are low)
//   bus_dout  UART write data (holds when strobes are low)
//   bus_w_en  UART write strobe
//   bus_r_en  UART read strobe
//   bus_din   UART read data, valid the cycle after bus_r_en
module uart_tx_sched #(
  parameter logic [7:0] UART_ADDRESS  = 8'h00,
  parameter logic [7:0] BAUD_INIT     = 8'd0,
  parameter logic [7:0] TIMEOUT_POLLS = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] ack,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_dout,
  output logic       bus_w_en,
  output logic       bus_r_en,
  input  logic [7:0] bus_din,
  output logic [1:0] err
);

  typedef enum logic [2:0] {INIT, IDLE, POLL_RD, POLL_CHK, WRITE} state_t;

  state_t     state;
  logic       sel;         // requester currently being served
  logic       last;        // requester served most recently
  logic       pick;        // arbitration result for this cycle
  logic [7:0] tx_byte_p0;  // byte captured at arbitration

  // Only tx_empty of the control register matters here.
  logic unused_din;
  assign unused_din = ^{bus_din[7:2], bus_din[0]};

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [7:0] poll_cnt;    // control-register reads issued for this byte
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_POLLS;
  assign err = 2'b00;
`endif

  // Round-robin: a lone request wins outright; with both pending the one
  // not served last wins. last resets to 1 so requester 0 goes first.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ~last;
  end

  // Arbitration stage: capture the winner's byte so later req/data changes
  // cannot affect the transfer.
  always_ff @(posedge clk) begin
    if (state == IDLE && (|req)) tx_byte_p0 <= pick ? data1 : data0;
  end

  // Outputs are registered alongside the next state so each strobe is high
  // exactly while the FSM sits in the state that owns it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      ack      <= 2'b00;
      bus_w_en <= 1'b0;
      bus_r_en <= 1'b0;
      bus_addr <= 8'h00;
      bus_dout <= 8'h00;
      sel      <= 1'b0;
      last     <= 1'b1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      err      <= 2'b00;
      poll_cnt <= 8'h00;
`endif
    end else begin
      ack      <= 2'b00;
      bus_w_en <= 1'b0;
      bus_r_en <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      err      <= 2'b00;
`endif
      case (state)
        // INIT spans the reset-release cycle plus the baud-write cycle;
        // bus_w_en itself marks that the write has been issued.
        INIT: begin
          if (!bus_w_en) begin
            bus_w_en <= 1'b1;
            bus_addr <= UART_ADDRESS;
            bus_dout <= BAUD_INIT;
          end else begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (|req) begin
            sel      <= pick;
            state    <= POLL_RD;
            bus_r_en <= 1'b1;
            bus_addr <= UART_ADDRESS + 8'd1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            poll_cnt <= 8'd1;
`endif
          end
        end
        POLL_RD: begin
          state <= POLL_CHK;
        end
        POLL_CHK: begin
          if (bus_din[1]) begin
            state    <= WRITE;
            bus_w_en <= 1'b1;
            bus_addr <= UART_ADDRESS + 8'd2;
            bus_dout <= tx_byte_p0;
            ack      <= sel ? 2'b10 : 2'b01;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          end else if (poll_cnt >= TIMEOUT_POLLS) begin
            // Give up: the WRITE slot carries err instead of a write.
            state <= WRITE;
            err   <= sel ? 2'b10 : 2'b01;
`endif
          end else begin
            state    <= POLL_RD;
            bus_r_en <= 1'b1;
            bus_addr <= UART_ADDRESS + 8'd1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            poll_cnt <= poll_cnt + 8'd1;
`endif
          end
        end
        WRITE: begin
          last  <= sel;
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam logic [7:0] BASE = 8'h00;
  localparam logic [7:0] BAUD = 8'h5C;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam logic [7:0] TO_POLLS = 8'd3;
  localparam int         MAX_BUSY = 2;
`else
  localparam logic [7:0] TO_POLLS = 8'd255;
  localparam int         MAX_BUSY = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic [7:0] bus_din = 8'h00;
  logic [1:0] ack, err;
  logic [7:0] bus_addr, bus_dout;
  logic       bus_w_en, bus_r_en;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending bytes per requester, zero-responses per
  // byte, who was served last, and where the address/data bus should rest.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         busy_plan[$];
  logic       model_last = 1'b1;
  logic [7:0] exp_addr = 8'h00;
  logic [7:0] exp_dout = 8'h00;

  uart_tx_sched #(
    .UART_ADDRESS (BASE),
    .BAUD_INIT    (BAUD),
    .TIMEOUT_POLLS(TO_POLLS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data0   (data0),
    .data1   (data1),
    .ack     (ack),
    .bus_addr(bus_addr),
    .bus_dout(bus_dout),
    .bus_w_en(bus_w_en),
    .bus_r_en(bus_r_en),
    .bus_din (bus_din),
    .err     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Requesters keep req high while they have bytes; the UART answers each
  // read with tx_empty=0 for the planned number of polls, then 1.
  task automatic run_traffic(input string name, input bit drop_early, input int max_cycles);
    int cyc, since, reads, busy_left, busy_cur, sel;
    bit first;
    logic [7:0] exp_byte;
    cyc = 0; since = 0; reads = 0; first = 1'b1;
    busy_cur  = (busy_plan.size() != 0) ? busy_plan.pop_front() : 0;
    busy_left = busy_cur;
    req = {q1.size() != 0, q0.size() != 0};
    if (q0.size() != 0) data0 = q0[0];
    if (q1.size() != 0) data1 = q1[0];
    while ((q0.size() != 0 || q1.size() != 0) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++; since++;
      checks++;
      if ((bus_w_en & bus_r_en) !== 1'b0 || err !== 2'b00)
        $display("FAIL %s_excl: w_en=%b r_en=%b err=%b, expected no overlap and err=00",
                 name, bus_w_en, bus_r_en, err);
      if ((bus_w_en & bus_r_en) !== 1'b0 || err !== 2'b00) errors++;
      if (drop_early && cyc == 1) begin
        req = 2'b00;
        data0 = ~data0;
        data1 = ~data1;
      end
      if (bus_r_en) begin
        exp_addr = BASE + 8'd1;
        reads++;
        if (busy_left > 0) begin
          bus_din = 8'($urandom) & 8'hFD;
          busy_left--;
        end else begin
          bus_din = 8'($urandom) | 8'h02;
        end
      end
      if (bus_w_en) begin
        if (q0.size() != 0 && q1.size() != 0) sel = model_last ? 0 : 1;
        else sel = (q0.size() != 0) ? 0 : 1;
        exp_byte = (sel == 0) ? q0[0] : q1[0];
        checks++;
        if (bus_addr !== BASE + 8'd2 || bus_dout !== exp_byte) begin
          errors++;
          $display("FAIL %s_write: addr=%h dout=%h, expected addr=%h dout=%h",
                   name, bus_addr, bus_dout, BASE + 8'd2, exp_byte);
        end
        checks++;
        if (ack !== ((sel == 0) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL %s_ack: ack=%b, expected requester %0d", name, ack, sel);
        end
        checks++;
        if (reads != busy_cur + 1) begin
          errors++;
          $display("FAIL %s_polls: reads=%0d, expected %0d", name, reads, busy_cur + 1);
        end
        checks++;
        if (since != (first ? 3 : 4) + 2 * busy_cur) begin
          errors++;
          $display("FAIL %s_latency: cycles=%0d, expected %0d", name, since,
                   (first ? 3 : 4) + 2 * busy_cur);
        end
        if (sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        model_last = sel[0];
        exp_addr = BASE + 8'd2;
        exp_dout = exp_byte;
        first = 1'b0; since = 0; reads = 0;
        busy_cur  = (busy_plan.size() != 0) ? busy_plan.pop_front() : 0;
        busy_left = busy_cur;
        if (!drop_early) begin
          req = {q1.size() != 0, q0.size() != 0};
          if (q0.size() != 0) data0 = q0[0];
          if (q1.size() != 0) data1 = q1[0];
        end
      end else begin
        checks++;
        if (ack !== 2'b00 || bus_addr !== exp_addr || bus_dout !== exp_dout) begin
          errors++;
          $display("FAIL %s_hold: ack=%b addr=%h dout=%h, expected ack=00 addr=%h dout=%h",
                   name, ack, bus_addr, bus_dout, exp_addr, exp_dout);
        end
      end
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d/%0d bytes left after %0d cycles, expected 0/0",
               name, q0.size(), q1.size(), cyc);
    end
    req = 2'b00;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus_w_en !== 1'b0 || bus_r_en !== 1'b0 || ack !== 2'b00 ||
          bus_addr !== exp_addr || bus_dout !== exp_dout) begin
        errors++;
        $display("FAIL %s_idle: w=%b r=%b ack=%b addr=%h dout=%h, expected quiet bus at %h/%h",
                 name, bus_w_en, bus_r_en, ack, bus_addr, bus_dout, exp_addr, exp_dout);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, err, bus_w_en, bus_r_en, bus_addr, bus_dout} !== 22'h0) begin
      errors++;
      $display("FAIL reset_state: ack=%b err=%b w=%b r=%b addr=%h dout=%h, expected all 0",
               ack, err, bus_w_en, bus_r_en, bus_addr, bus_dout);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_w_en !== 1'b1 || bus_r_en !== 1'b0 || bus_addr !== BASE || bus_dout !== BAUD) begin
      errors++;
      $display("FAIL reset_baud: w=%b r=%b addr=%h dout=%h, expected w=1 r=0 addr=%h dout=%h",
               bus_w_en, bus_r_en, bus_addr, bus_dout, BASE, BAUD);
    end
    exp_addr = BASE; exp_dout = BAUD; model_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus_w_en !== 1'b0 || bus_r_en !== 1'b0 || ack !== 2'b00 || err !== 2'b00 ||
          bus_addr !== exp_addr || bus_dout !== exp_dout) begin
        errors++;
        $display("FAIL reset_idle: w=%b r=%b ack=%b err=%b addr=%h dout=%h, expected quiet",
                 bus_w_en, bus_r_en, ack, err, bus_addr, bus_dout);
      end
    end
  endtask

  task automatic test_round_robin();
    q0 = {8'h11, 8'h11};
    q1 = {8'h22};
    busy_plan = {};
    run_traffic("round_robin", 1'b0, 100);
  endtask

  task automatic test_single();
    q0 = {8'hA5};
    q1 = {};
    busy_plan = {0};
    run_traffic("single", 1'b0, 50);
  endtask

  task automatic test_busy_poll();
    q0 = {8'h3E};
    q1 = {};
    busy_plan = {MAX_BUSY};
    run_traffic("busy_poll", 1'b0, 50);
  endtask

  task automatic test_drop_req();
    q0 = {};
    q1 = {8'hC3};
    busy_plan = {1};
    run_traffic("drop_req", 1'b1, 50);
  endtask

  task automatic test_random();
    int n0, n1;
    for (int round = 0; round < 4; round++) begin
      q0.delete(); q1.delete(); busy_plan.delete();
      n0 = $urandom_range(0, 6);
      n1 = $urandom_range(1, 6);
      for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
      for (int i = 0; i < n0 + n1; i++) busy_plan.push_back($urandom_range(0, MAX_BUSY));
      run_traffic("random", 1'b0, 1000);
    end
  endtask

  task automatic test_reset_mid();
    req = 2'b01; data0 = 8'h3C; bus_din = 8'h02;
    @(negedge clk);
    checks++;
    if (bus_r_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_poll: r_en=%b, expected 1", bus_r_en);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({ack, err, bus_w_en, bus_r_en, bus_addr, bus_dout} !== 22'h0) begin
      errors++;
      $display("FAIL reset_mid_clear: ack=%b err=%b w=%b r=%b addr=%h dout=%h, expected all 0",
               ack, err, bus_w_en, bus_r_en, bus_addr, bus_dout);
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if ({ack, err, bus_w_en, bus_r_en} !== 6'h0) begin
      errors++;
      $display("FAIL reset_mid_held: ack=%b err=%b w=%b r=%b, expected all 0",
               ack, err, bus_w_en, bus_r_en);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_w_en !== 1'b1 || bus_addr !== BASE || bus_dout !== BAUD || ack !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_baud: w=%b addr=%h dout=%h ack=%b, expected w=1 addr=%h dout=%h ack=00",
               bus_w_en, bus_addr, bus_dout, ack, BASE, BAUD);
    end
    exp_addr = BASE; exp_dout = BAUD; model_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus_w_en !== 1'b0 || bus_r_en !== 1'b0 || ack !== 2'b00 || err !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_dropped: w=%b r=%b ack=%b err=%b, expected quiet",
                 bus_w_en, bus_r_en, ack, err);
      end
    end
  endtask

`ifdef UART_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int reads;
    reads = 0;
    req = 2'b01; data0 = 8'h77; bus_din = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus_r_en) reads++;
      checks++;
      if (bus_w_en !== 1'b0 || ack !== 2'b00) begin
        errors++;
        $display("FAIL timeout_nowrite: cycle %0d w=%b ack=%b, expected w=0 ack=00",
                 c, bus_w_en, ack);
      end
      checks++;
      if (err !== ((c == 7) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL timeout_err: cycle %0d err=%b, expected %b",
                 c, err, (c == 7) ? 2'b01 : 2'b00);
      end
      if (c == 7) req = 2'b00;
    end
    checks++;
    if (reads != TO_POLLS) begin
      errors++;
      $display("FAIL timeout_reads: reads=%0d, expected %0d", reads, TO_POLLS);
    end
    exp_addr = BASE + 8'd1;
    // The dropped byte still counts as served, so requester 1 now goes first.
    model_last = 1'b0;
    q0 = {8'h5A};
    q1 = {8'hA6};
    busy_plan = {};
    run_traffic("timeout_rr", 1'b0, 100);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_busy_poll();
    test_drop_req();
    test_random();
    test_reset_mid();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter UART_ADDRESS, default 8'h00, meaning base address of the UART register block (baud = base, control = base+1, buffer = base+2).
REQ-002 SHALL have parameter BAUD_INIT, default 8'd0, meaning prescaler value written to the baud register after reset.
REQ-003 SHALL have parameter TIMEOUT_POLLS, default 8'd255, meaning maximum control-register polls per byte (used only with the timeout macro).
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; asynchronous, active-low.
REQ-006 SHALL have port req, input, 2, meaning per-requester byte request; held high until the matching ack.
REQ-007 SHALL have port data0, input, 8, meaning requester 0 byte; stable while req[0] is high.
REQ-008 SHALL have port data1, input, 8, meaning requester 1 byte; stable while req[1] is high.
REQ-009 SHALL have port ack, output, 2, meaning one-cycle pulse: byte of that requester written to UART.
REQ-010 SHALL have port bus_addr, output, 8, meaning UART register address.
REQ-011 SHALL have port bus_dout, output, 8, meaning write data to UART din.
REQ-012 SHALL have port bus_w_en, output, 1, meaning UART write strobe.
REQ-013 SHALL have port bus_r_en, output, 1, meaning UART read strobe.
REQ-014 SHALL have port bus_din, input, 8, meaning UART dout; registered, valid the cycle after bus_r_en.
REQ-015 SHALL have port err, output, 2, meaning one-cycle pulse: byte of that requester dropped on timeout.

Function
REQ-016 SHALL implement FSM states INIT, IDLE, POLL_RD, POLL_CHK, WRITE; all bus outputs, ack and err are registered, asserted exactly during the cycle the FSM occupies the owning state.
REQ-017 SHALL in INIT (one cycle) drive bus_addr=UART_ADDRESS, bus_dout=BAUD_INIT, bus_w_en=1; then go to IDLE.
REQ-018 SHALL in IDLE, when any req bit is high, select a requester, latch its data byte, go to POLL_RD; otherwise stay in IDLE.
REQ-019 SHALL arbitrate round-robin: with both req high, select the requester not served last; after reset, requester 0 has priority.
REQ-020 SHALL in POLL_RD drive bus_addr=UART_ADDRESS+1, bus_r_en=1; go to POLL_CHK.
REQ-021 SHALL in POLL_CHK go to WRITE if bus_din[1] (tx_empty) is 1, else to POLL_RD.
REQ-022 SHALL in WRITE drive bus_addr=UART_ADDRESS+2, bus_dout=latched byte, bus_w_en=1, ack[selected]=1; update round-robin pointer; go to IDLE.
REQ-023 SHALL give best-case latency of 3 cycles from the IDLE cycle sampling req to the WRITE/ack cycle; each failed poll adds 2 cycles.
REQ-024 SHALL never assert bus_w_en and bus_r_en together, nor ack and err together, nor more than one bit of ack or err.
REQ-025 SHALL ignore req changes after latching; a requester dropping req before ack still has its latched byte sent and acked.
REQ-026 SHALL hold bus_addr and bus_dout at their last values when strobes are low.

Reset
REQ-027 SHALL, on rst low, immediately clear FSM to INIT, ack=0, err=0, bus_w_en=0, bus_r_en=0, bus_addr=0, bus_dout=0, round-robin pointer to favour requester 0, poll counter=0.
REQ-028 SHALL drop any in-flight byte on reset mid-operation with no ack or err, and re-run INIT after release.

Configuration
REQ-029 SHALL, with macro UART_TX_SCHED_TIMEOUT_EN defined, count polls per byte; when the count reaches TIMEOUT_POLLS with tx_empty still 0, pulse err[selected] for one cycle in place of WRITE, skip the write, update the round-robin pointer, return to IDLE.
REQ-030 SHALL, without UART_TX_SCHED_TIMEOUT_EN, poll indefinitely, hold err at 0 and contain no poll counter.

Verification
REQ-031 SHALL cover: reset release -> one cycle bus_w_en=1, bus_addr=8'h00, bus_dout=BAUD_INIT, then idle strobes low.
REQ-032 SHALL cover: req=2'b01, data0=8'hA5, bus_din=8'h02 -> read at 8'h01, then write 8'hA5 to 8'h02 with ack=2'b01, 3 cycles after IDLE sample.
REQ-033 SHALL cover: req=2'b11 held, data0=8'h11, data1=8'h22, tx_empty always 1 -> writes alternate 8'h11, 8'h22, 8'h11, ack alternates 01, 10, 01.
REQ-034 SHALL cover: bus_din=8'h00 for 4 polls then 8'h02 -> 4 extra poll pairs, then single write and ack, no early write.
REQ-035 SHALL cover: rst low during POLL_CHK -> all outputs 0 immediately, no ack; after release INIT baud write repeats.
REQ-036 SHALL cover with UART_TX_SCHED_TIMEOUT_EN, TIMEOUT_POLLS=3, bus_din=8'h00 -> 3 reads, err=2'b01 pulse, no write, return to IDLE.
